// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Purpose : Shared constants for the game screen renderer: coordinate width,
//           colour encodings, the gap LFSR tap mask and its step function.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package game_pkg;

    localparam int COORD_W = 10;

    // x^10 + x^7 + 1 : feedback taken from bits 9 and 6 of a left-shifting register
    localparam logic [COORD_W-1:0] LFSR_TAPS = 10'h240;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } colour_t;

    localparam colour_t COL_BIRD  = '{r: 3'd5, g: 3'd5, b: 2'd3};
    localparam colour_t COL_TUBE  = '{r: 3'd0, g: 3'd7, b: 2'd0};
    localparam colour_t COL_SKY   = '{r: 3'd0, g: 3'd5, b: 2'd3};
    localparam colour_t COL_BLACK = '{r: 3'd0, g: 3'd0, b: 2'd0};

    // One Fibonacci step: shift left, new LSB is the parity of the tapped bits.
    function automatic logic [COORD_W-1:0] lfsr_next(input logic [COORD_W-1:0] s);
        return {s[COORD_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scene_renderer_if.sv
`default_nettype none
// ============================================================================
// Module  : scene_renderer_if
// Purpose : Pixel/game bus between the VGA timing + game logic (master) and
//           the scene renderer (slave).
// Signals : x, y, video_on      - current pixel position and active-region flag
//           pos_x_tubes         - packed pipe left edges, pipe i in [10i+9:10i]
//           pos_y_bird          - bird top row
//           clear_lose / lose   - collision flag clear request / sticky flag
//           r, g, b             - registered colour to the DAC
// Rev     : 1.0  initial release
// ============================================================================
interface scene_renderer_if #(
    parameter int N_TUBES = 3
);
    logic [game_pkg::COORD_W-1:0]         x;
    logic [game_pkg::COORD_W-1:0]         y;
    logic                                 video_on;
    logic [game_pkg::COORD_W*N_TUBES-1:0] pos_x_tubes;
    logic [game_pkg::COORD_W-1:0]         pos_y_bird;
    logic                                 clear_lose;
    logic                                 lose;
    logic [2:0]                           r;
    logic [2:0]                           g;
    logic [1:0]                           b;

    modport master (
        output x, y, video_on, pos_x_tubes, pos_y_bird, clear_lose,
        input  lose, r, g, b
    );

    modport slave (
        input  x, y, video_on, pos_x_tubes, pos_y_bird, clear_lose,
        output lose, r, g, b
    );
endinterface
`default_nettype wire

// File: rtl/tube_gap_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : tube_gap_lfsr
// Purpose : Per-pipe gap generator. A 10-bit Fibonacci LFSR that advances one
//           step per 'step' pulse; the gap top row is GAP_MIN plus the low
//           log2(GAP_RANGE) bits of the register.
// Ports   : clk, reset (async, active-high), step (advance once),
//           seed (reset value, must be non-zero), top (gap top row)
// Rev     : 1.0  initial release
// ============================================================================
module tube_gap_lfsr
    import game_pkg::*;
#(
    parameter int GAP_MIN   = 40,
    parameter int GAP_RANGE = 256    // power of two, 2..1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic [COORD_W-1:0] seed,
    output logic [COORD_W-1:0] top
);

    localparam int RANGE_W = $clog2(GAP_RANGE);

    logic [COORD_W-1:0] r_lfsr;

    // seed is tied to a per-instance constant, so the async load is a plain preset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= seed;
        end else if (step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // power-of-two range makes the modulo a simple bit select
    assign top = COORD_W'(GAP_MIN) + COORD_W'(r_lfsr[RANGE_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/scene_renderer.sv
`default_nettype none
// ============================================================================
// Module  : scene_renderer
// Purpose : Two-stage pipelined pixel colour generator: bird sprite, N_TUBES
//           pipes with LFSR gap heights, blanking, and a sticky collision flag.
// Ports   : clk    - pixel clock
//           reset  - asynchronous, active-high
//           bus    - scene_renderer_if.slave (pixel position, object positions,
//                    clear_lose in; lose, r, g, b out)
// Latency : colour and blanking appear exactly 2 clocks after x/y/video_on.
// Rev     : 1.0  initial release
// ============================================================================
module scene_renderer
    import game_pkg::*;
#(
    parameter int                 N_TUBES   = 3,
    parameter int                 TUBE_W    = 40,
    parameter int                 GAP_H     = 120,
    parameter int                 GAP_MIN   = 40,
    parameter int                 GAP_RANGE = 256,
    parameter int                 BIRD_X    = 225,
    parameter int                 BIRD_S    = 25,
    parameter int                 SCREEN_H  = 480,
    parameter logic [COORD_W-1:0] SEED      = 10'h2A5
) (
    input  logic               clk,
    input  logic               reset,
    scene_renderer_if.slave    bus
);

    // Comparisons run one bit wider so edge+size never wraps around.
    localparam int W = COORD_W + 1;

    localparam logic [W-1:0] C_BIRD_X0 = W'(BIRD_X);
    localparam logic [W-1:0] C_BIRD_X1 = W'(BIRD_X + BIRD_S);
    localparam logic [W-1:0] C_BIRD_S  = W'(BIRD_S);
    localparam logic [W-1:0] C_TUBE_W  = W'(TUBE_W);
    localparam logic [W-1:0] C_GAP_H   = W'(GAP_H);
    localparam logic [W-1:0] C_SCREEN_H = W'(SCREEN_H);

    logic [W-1:0] w_x;
    logic [W-1:0] w_y;
    logic [W-1:0] w_bird_y;
    logic         w_bird_hit;
    logic         w_low_bird;
    logic [N_TUBES-1:0] w_span_hit;   // pixel lies in pipe i's column range
    logic [N_TUBES-1:0] w_gap_hit;    // ... and inside its gap

    assign w_x      = {1'b0, bus.x};
    assign w_y      = {1'b0, bus.y};
    assign w_bird_y = {1'b0, bus.pos_y_bird};

    assign w_bird_hit = (w_x >= C_BIRD_X0) && (w_x < C_BIRD_X1) &&
                        (w_y >= w_bird_y)  && (w_y < w_bird_y + C_BIRD_S);

    // bird sinking through the bottom of the screen is a loss regardless of x/y
    assign w_low_bird = (w_bird_y + C_BIRD_S) > C_SCREEN_H;

    // ------------------------------------------------------------------------
    // Per-pipe gap generator, wrap detection and hit tests
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < N_TUBES; i++) begin : g_tube
        localparam logic [COORD_W-1:0] C_SEED = SEED ^ COORD_W'(i);

        logic [COORD_W-1:0] w_pos;
        logic [COORD_W-1:0] r_prev_x;
        logic [COORD_W-1:0] w_top;
        logic               w_step;
        logic [W-1:0]       w_left;
        logic [W-1:0]       w_top_w;

        assign w_pos = bus.pos_x_tubes[COORD_W*i +: COORD_W];

        // A jump to the right by more than one pixel means the pipe scrolled off
        // the left and re-entered on the right: draw a fresh gap for it.
        assign w_step = {1'b0, w_pos} > ({1'b0, r_prev_x} + W'(1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_prev_x <= '0;
            end else begin
                r_prev_x <= w_pos;
            end
        end

        tube_gap_lfsr #(
            .GAP_MIN   (GAP_MIN),
            .GAP_RANGE (GAP_RANGE)
        ) u_gap_lfsr (
            .clk   (clk),
            .reset (reset),
            .step  (w_step),
            .seed  (C_SEED),
            .top   (w_top)
        );

        assign w_left  = {1'b0, w_pos};
        assign w_top_w = {1'b0, w_top};

        assign w_span_hit[i] = (w_x >= w_left) && (w_x < w_left + C_TUBE_W);
        assign w_gap_hit[i]  = w_span_hit[i] &&
                               (w_y >= w_top_w) && (w_y < w_top_w + C_GAP_H);
    end

    // ------------------------------------------------------------------------
    // Stage 1: register hit flags and blanking
    // ------------------------------------------------------------------------
    logic               r_video_on;
    logic               r_bird_hit;
    logic               r_low_bird;
    logic [N_TUBES-1:0] r_span_hit;
    logic [N_TUBES-1:0] r_gap_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_video_on <= 1'b0;
            r_bird_hit <= 1'b0;
            r_low_bird <= 1'b0;
            r_span_hit <= '0;
            r_gap_hit  <= '0;
        end else begin
            r_video_on <= bus.video_on;
            r_bird_hit <= w_bird_hit;
            r_low_bird <= w_low_bird;
            r_span_hit <= w_span_hit;
            r_gap_hit  <= w_gap_hit;
        end
    end

    // A pipe's body is its column minus its gap. Every pipe shares one colour,
    // so "lowest-index body wins" reduces to "any body".
    logic [N_TUBES-1:0] w_body_hit;
    logic               w_any_body;
    logic               w_collide;

    assign w_body_hit = r_span_hit & ~r_gap_hit;
    assign w_any_body = |w_body_hit;
    assign w_collide  = r_video_on && ((r_bird_hit && w_any_body) || r_low_bird);

    // ------------------------------------------------------------------------
    // Stage 2: colour priority mux and sticky collision flag
    // ------------------------------------------------------------------------
    colour_t r_colour;
    logic    r_lose;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_colour <= COL_BLACK;
        end else if (!r_video_on) begin
            r_colour <= COL_BLACK;
        end else if (r_bird_hit) begin
            r_colour <= COL_BIRD;
        end else if (w_any_body) begin
            r_colour <= COL_TUBE;
        end else begin
            r_colour <= COL_SKY;
        end
    end

    // set takes precedence over a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lose <= 1'b0;
        end else if (w_collide) begin
            r_lose <= 1'b1;
        end else if (bus.clear_lose) begin
            r_lose <= 1'b0;
        end
    end

    assign bus.r    = r_colour.r;
    assign bus.g    = r_colour.g;
    assign bus.b    = r_colour.b;
    assign bus.lose = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_scene_renderer.sv
`default_nettype none
// ============================================================================
// Module  : tb_scene_renderer
// Purpose : Self-checking bench for scene_renderer: vector table plus
//           scoreboard for colours, hand sequences for reset, gap wrap and
//           the sticky collision flag.
// Rev     : 1.0  initial release
// ============================================================================
module tb_scene_renderer;

    localparam int N       = 3;
    localparam int GAP_H   = 120;
    localparam int GAP_MIN = 40;
    localparam logic [9:0] SEED = 10'h2A5;

    localparam logic [7:0] C_BIRD  = {3'd5, 3'd5, 2'd3};
    localparam logic [7:0] C_TUBE  = {3'd0, 3'd7, 2'd0};
    localparam logic [7:0] C_SKY   = {3'd0, 3'd5, 2'd3};
    localparam logic [7:0] C_BLACK = 8'h00;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scene_renderer_if #(.N_TUBES(N)) bus ();

    scene_renderer #(.N_TUBES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    endtask

    // ---------------- reference gap model ----------------
    function automatic logic [9:0] m_next(input logic [9:0] s);
        return {s[8:0], s[9] ^ s[6]};
    endfunction

    logic [9:0] m_lfsr [N];
    logic [9:0] m_prev [N];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_lfsr[i] <= SEED ^ 10'(i);
                m_prev[i] <= '0;
            end else begin
                if ({1'b0, bus.pos_x_tubes[10*i +: 10]} > {1'b0, m_prev[i]} + 11'd1)
                    m_lfsr[i] <= m_next(m_lfsr[i]);
                m_prev[i] <= bus.pos_x_tubes[10*i +: 10];
            end
        end
    end

    function automatic int top_of(input logic [9:0] l);
        return GAP_MIN + int'(l[7:0]);
    endfunction

    // ---------------- colour scoreboard ----------------
    typedef struct {
        int         due;
        logic [7:0] rgb;
        string      nm;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            if (sbq[0].due == cyc) begin
                e = sbq.pop_front();
                check(e.nm, 32'({bus.r, bus.g, bus.b}), 32'(e.rgb));
            end else if (sbq[0].due < cyc) begin
                e = sbq.pop_front();
                n_checks++;
                $display("FAIL %s: output slot missed, expected 0x%0h", e.nm, e.rgb);
            end
        end
    end

    task automatic drive(input int x, input int y, input bit von,
                         input logic [7:0] rgb, input string nm);
        @(negedge clk);
        bus.x        = 10'(x);
        bus.y        = 10'(y);
        bus.video_on = von;
        sbq.push_back('{due: cyc + 2, rgb: rgb, nm: nm});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pipes(input int p0, input int p1, input int p2);
        @(negedge clk);
        bus.pos_x_tubes = {10'(p2), 10'(p1), 10'(p0)};
    endtask

    // probe the four gap boundary rows of one pipe
    task automatic check_pipe(input int i, input int xi, input int t);
        drive(xi + 1, t - 1,         1'b1, C_TUBE, $sformatf("pipe%0d_above_gap", i));
        drive(xi + 1, t,             1'b1, C_SKY,  $sformatf("pipe%0d_gap_top", i));
        drive(xi + 1, t + GAP_H - 1, 1'b1, C_SKY,  $sformatf("pipe%0d_gap_bottom", i));
        drive(xi + 1, t + GAP_H,     1'b1, C_TUBE, $sformatf("pipe%0d_below_gap", i));
    endtask

    task automatic chk_lose(input logic exp_v, input string nm);
        check(nm, 32'(bus.lose), 32'(exp_v));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         x;
        int         y;      // absolute row, or offset from pipe0 gap top when rel
        bit         rel;
        bit         von;
        logic [7:0] rgb;
        string      nm;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] snap [N];
        logic [9:0] nx;
        int t0, t1, t2, bird_y;

        // pipes: p0=300, p1=80, p2=90 (p1/p2 overlap at x=90..119); bird top 200
        tbl.push_back('{10,  10,  0, 1, C_SKY,   "sky"});
        tbl.push_back('{10,  10,  0, 0, C_BLACK, "blank"});
        tbl.push_back('{230, 201, 0, 1, C_BIRD,  "bird"});
        tbl.push_back('{249, 224, 0, 1, C_BIRD,  "bird_corner"});
        tbl.push_back('{250, 201, 0, 1, C_SKY,   "bird_right_edge"});
        tbl.push_back('{230, 225, 0, 1, C_SKY,   "bird_bottom_edge"});
        tbl.push_back('{224, 201, 0, 1, C_SKY,   "bird_left_edge"});
        tbl.push_back('{100, 0,   0, 1, C_TUBE,  "pipe_overlap"});
        tbl.push_back('{125, 479, 0, 1, C_TUBE,  "pipe2_only"});
        tbl.push_back('{301, -1,  1, 1, C_TUBE,  "above_gap"});
        tbl.push_back('{301, 0,   1, 1, C_SKY,   "gap_top"});
        tbl.push_back('{301, GAP_H - 1, 1, 1, C_SKY, "gap_bottom"});
        tbl.push_back('{301, GAP_H, 1, 1, C_TUBE, "below_gap"});
        tbl.push_back('{339, -1,  1, 1, C_TUBE,  "pipe_right_col"});
        tbl.push_back('{340, -1,  1, 1, C_SKY,   "pipe_right_edge"});
        tbl.push_back('{300, -1,  1, 1, C_TUBE,  "pipe_left_col"});
        tbl.push_back('{299, -1,  1, 1, C_SKY,   "pipe_left_edge"});
        tbl.push_back('{301, -1,  1, 0, C_BLACK, "blank_on_pipe"});

        // ---- reset with the bird pixel presented ----
        reset           = 1'b1;
        bus.x           = 10'd230;
        bus.y           = 10'd201;
        bus.video_on    = 1'b1;
        bus.pos_y_bird  = 10'd200;
        bus.clear_lose  = 1'b0;
        bus.pos_x_tubes = {10'd90, 10'd80, 10'd300};
        idle(3);
        check("reset_rgb", 32'({bus.r, bus.g, bus.b}), 32'(C_BLACK));
        chk_lose(1'b0, "reset_lose");
        @(negedge clk);
        reset = 1'b0;
        sbq.push_back('{due: cyc + 1, rgb: C_BLACK, nm: "release_clk1"});
        sbq.push_back('{due: cyc + 2, rgb: C_BIRD,  nm: "release_clk2"});

        // ---- table, one vector per clock ----
        foreach (tbl[k]) begin
            t0 = top_of(m_lfsr[0]);
            drive(tbl[k].x, tbl[k].rel ? t0 + tbl[k].y : tbl[k].y,
                  tbl[k].von, tbl[k].rgb, tbl[k].nm);
        end
        idle(3);

        // ---- asynchronous reset mid-frame ----
        drive(230, 201, 1'b1, C_BIRD, "pre_reset_bird");
        idle(3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("midreset_rgb", 32'({bus.r, bus.g, bus.b}), 32'(C_BLACK));
        chk_lose(1'b0, "midreset_lose");
        @(negedge clk);
        reset = 1'b0;
        sbq.push_back('{due: cyc + 1, rgb: C_BLACK, nm: "midrelease_clk1"});
        sbq.push_back('{due: cyc + 2, rgb: C_BIRD,  nm: "midrelease_clk2"});
        idle(3);

        // ---- gap reseed on wrap ----
        set_pipes(300, 400, 500);
        idle(2);
        set_pipes(0, 400, 500);           // moving left: no reseed
        idle(2);
        for (int i = 0; i < N; i++) snap[i] = m_lfsr[i];
        set_pipes(640, 400, 500);         // right-side re-entry of pipe 0 only
        idle(4);
        nx = m_next(snap[0]);
        t0 = top_of(nx);
        t1 = top_of(snap[1]);
        t2 = top_of(snap[2]);
        check_pipe(0, 640, t0);
        check_pipe(1, 400, t1);
        check_pipe(2, 500, t2);
        set_pipes(600, 400, 500);         // decrement: gap must stay put
        idle(2);
        check_pipe(0, 600, t0);

        set_pipes(0, 0, 0);
        idle(2);
        for (int i = 0; i < N; i++) snap[i] = m_lfsr[i];
        set_pipes(300, 400, 500);         // all three wrap together
        idle(3);
        nx = m_next(snap[0]); t0 = top_of(nx);
        nx = m_next(snap[1]); t1 = top_of(nx);
        nx = m_next(snap[2]); t2 = top_of(nx);
        check_pipe(0, 300, t0);
        check_pipe(1, 400, t1);
        check_pipe(2, 500, t2);
        idle(3);

        // ---- collision flag ----
        set_pipes(220, 400, 500);         // pipe 0 now covers the bird column
        bird_y = t0 + GAP_H + 5;          // bird entirely below the gap
        bus.pos_y_bird = 10'(bird_y);
        bus.x = 10'd10; bus.y = 10'd10; bus.video_on = 1'b0;
        idle(3);
        chk_lose(1'b0, "lose_idle");

        drive(230, bird_y + 1, 1'b1, C_BIRD, "bird_over_pipe");
        drive(10, 10, 1'b0, C_BLACK, "after_hit_blank");
        @(negedge clk);
        chk_lose(1'b1, "lose_set");
        idle(1000);
        chk_lose(1'b1, "lose_sticky_1000");
        @(negedge clk);
        bus.clear_lose = 1'b1;
        @(negedge clk);
        bus.clear_lose = 1'b0;
        chk_lose(1'b0, "lose_cleared");

        @(negedge clk);
        bus.x = 10'd230; bus.y = 10'(bird_y + 1); bus.video_on = 1'b1;
        idle(2);
        chk_lose(1'b1, "lose_reset_again");
        bus.clear_lose = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_lose(1'b1, "set_beats_clear");
        end
        bus.clear_lose = 1'b0;
        bus.x = 10'd10; bus.y = 10'd10; bus.video_on = 1'b0;
        idle(3);
        bus.clear_lose = 1'b1;
        @(negedge clk);
        bus.clear_lose = 1'b0;
        chk_lose(1'b0, "lose_cleared_2");

        // bird bottom exactly on the last line is legal, one more is a loss
        bus.pos_y_bird = 10'd455;
        drive(10, 10, 1'b1, C_SKY, "sky_low_bird_ok");
        idle(3);
        chk_lose(1'b0, "bird_at_floor");
        bus.pos_y_bird = 10'd460;
        bus.video_on = 1'b0;
        idle(3);
        chk_lose(1'b0, "low_bird_blanked");
        drive(10, 10, 1'b1, C_SKY, "sky_low_bird");
        idle(2);
        chk_lose(1'b1, "bird_below_floor");

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_checks += sbq.size();
            $display("FAIL scoreboard_drain: %0d expected outputs never seen, required 0", sbq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
